// File: rtl/sobel_stream_out.sv
// sobel_stream_out: output stage of the Sobel edge filter.
// Takes the valid-only gradient stream and optionally binarises it against
// a threshold latched once per frame. Each pixel is tagged with sof/eol/eof,
// queued in a small FIFO and presented on a registered valid/ready stream.
//
// Output handshake: a beat transfers on any rising clk edge where
// m_valid && m_ready. While m_valid is high and m_ready is low, m_data and
// all tags are held stable. m_valid never drops without a transfer, except
// on rst.
module sobel_stream_out #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] pixel_in,
  input  logic       thresh_en,
  input  logic [7:0] threshold,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eol,
  output logic       m_eof,
  output logic       overflow,
  output logic       frame_done
);

  localparam int OUT_W = WIDTH - 2;
  localparam int OUT_H = HEIGHT - 2;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  // Beat layout: {sof, eol, eof, data[7:0]}
  localparam int BW = 11;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          en_q;
  logic [7:0]    thr_q;

  logic          s1_valid_q;
  logic [BW-1:0] s1_q;

  logic [BW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic          out_valid_q;
  logic [BW-1:0] out_q;
  logic          overflow_q;
  logic          frame_done_q;

  logic          sof_w, eol_w, eof_w;
  logic          en_eff;
  logic [7:0]    thr_eff;
  logic [7:0]    data_w;
  logic          pop, push_ok, drop;

  // Tag generation and threshold selection for the incoming pixel; the sof
  // pixel uses the live inputs, the rest of the frame uses the latched copy.
  always_comb begin
    sof_w   = (col_q == '0) && (row_q == '0);
    eol_w   = (col_q == CW'(OUT_W - 1));
    eof_w   = eol_w && (row_q == RW'(OUT_H - 1));
    en_eff  = sof_w ? thresh_en : en_q;
    thr_eff = sof_w ? threshold : thr_q;
    data_w  = pixel_in;
    if (en_eff) data_w = (pixel_in >= thr_eff) ? 8'hFF : 8'h00;
  end

  // Frame geometry counters and per-frame threshold latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      en_q  <= 1'b0;
      thr_q <= '0;
    end else if (valid_in) begin
      if (sof_w) begin
        en_q  <= thresh_en;
        thr_q <= threshold;
      end
      if (eol_w) begin
        col_q <= '0;
        row_q <= eof_w ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Stage 1 register: loaded every cycle, never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= valid_in;
      s1_q       <= {sof_w, eol_w, eof_w, data_w};
    end
  end

  // FIFO control: pop whenever the output register is free or draining, and
  // accept a push when there is room or a slot frees up in the same cycle.
  always_comb begin
    pop     = (count_q != '0) && (!out_valid_q || m_ready);
    push_ok = s1_valid_q && ((count_q < (AW+1)'(FIFO_DEPTH)) || pop);
    drop    = s1_valid_q && !push_ok;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= s1_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Output register, sticky overflow and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (pop) begin
        out_valid_q <= 1'b1;
        out_q       <= mem_q[rd_ptr_q];
      end else if (m_ready) begin
        out_valid_q <= 1'b0;
      end
      overflow_q   <= overflow_q | drop;
      frame_done_q <= out_valid_q && m_ready && out_q[8];
    end
  end

  assign m_valid    = out_valid_q;
  assign m_data     = out_q[7:0];
  assign m_sof      = out_q[10];
  assign m_eol      = out_q[9];
  assign m_eof      = out_q[8];
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_stream_out.sv
// Bench for sobel_stream_out with a 6x5 input image (4x3 = 12 beats/frame)
// and a 4-entry FIFO.
module tb_sobel_stream_out;

  localparam int W = 6;
  localparam int H = 5;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] pixel_in;
  logic       thresh_en;
  logic [7:0] threshold;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sof, m_eol, m_eof;
  logic       overflow;
  logic       frame_done;

  int total  = 0;
  int bad    = 0;
  int fd_cnt = 0;

  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];

  sobel_stream_out #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .pixel_in  (pixel_in),
    .thresh_en (thresh_en),
    .threshold (threshold),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_eof     (m_eof),
    .overflow  (overflow),
    .frame_done(frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  // Output monitor: record every handshaken beat and every frame_done cycle.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) obs_q.push_back({m_sof, m_eol, m_eof, m_data});
    if (!rst && frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_px(input logic [7:0] p);
    valid_in = 1'b1;
    pixel_in = p;
    tick();
    valid_in = 1'b0;
  endtask

  // Expected beat for position idx of a 12-beat frame carrying data d.
  function automatic logic [10:0] beat(input int idx, input logic [7:0] d);
    int k;
    k = idx % 12;
    return {(k == 0), ((k % 4) == 3), (k == 11), d};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b1;
    pixel_in = 8'hAA;
    tick();
    tick();
    total++;
    if ({m_valid, m_data, m_sof, m_eol, m_eof, overflow, frame_done} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {m_valid, m_data, m_sof, m_eol, m_eof, overflow, frame_done});
    end
    valid_in = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_valid: got %b want 0", m_valid);
    end
    obs_q.delete();
  endtask

  task automatic test_raw();
    int fd0;
    fd0 = fd_cnt;
    thresh_en = 1'b0;
    m_ready = 1'b1;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      push_px(8'(i));
      exp_q.push_back(beat(i, 8'(i)));
      if (i == 1) begin
        total++;
        if (m_valid !== 1'b0) begin
          bad++;
          $display("FAIL raw_latency_early: m_valid got %b want 0", m_valid);
        end
      end
      if (i == 2) begin
        total++;
        if ({m_valid, m_sof, m_data} !== {1'b1, 1'b1, 8'd0}) begin
          bad++;
          $display("FAIL raw_latency_first: got v=%b sof=%b d=%0d want v=1 sof=1 d=0", m_valid, m_sof, m_data);
        end
      end
    end
    repeat (6) tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL raw_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      total++;
      if (obs_q[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL raw_beat%0d: got %h want %h", j, obs_q[j], exp_q[j]);
      end
    end
    total++;
    if (fd_cnt - fd0 != 1) begin
      bad++;
      $display("FAIL raw_frame_done: got %0d pulses want 1", fd_cnt - fd0);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL raw_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_binarise();
    logic [7:0] pat [4];
    logic [7:0] res [4];
    pat = '{8'd99, 8'd100, 8'd255, 8'd0};
    res = '{8'd0, 8'd255, 8'd255, 8'd0};
    m_ready = 1'b1;
    thresh_en = 1'b1;
    threshold = 8'd100;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      // Mid-frame change must be ignored; frame 2 picks up en=1, thr=0.
      if (i == 4) begin
        threshold = 8'd0;
        thresh_en = 1'b0;
      end
      if (i == 12) thresh_en = 1'b1;
      push_px(pat[i % 4]);
      exp_q.push_back(beat(i, (i < 12) ? res[i % 4] : 8'd255));
    end
    repeat (6) tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bin_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      total++;
      if (obs_q[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL bin_beat%0d: got %h want %h", j, obs_q[j], exp_q[j]);
      end
    end
    thresh_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int fd0;
    int keep [8];
    keep = '{0, 1, 2, 3, 4, 9, 10, 11};
    fd0 = fd_cnt;
    thresh_en = 1'b0;
    m_ready = 1'b0;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      push_px(8'(16 + i));
      if (i >= 2 && i <= 9) begin
        total++;
        if ({m_valid, m_sof, m_data} !== {1'b1, 1'b1, 8'd16}) begin
          bad++;
          $display("FAIL bp_hold_cycle%0d: got v=%b sof=%b d=%0d want v=1 sof=1 d=16", i, m_valid, m_sof, m_data);
        end
      end
      if (i == 9) m_ready = 1'b1;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(beat(keep[k], 8'(16 + keep[k])));
    repeat (12) tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      total++;
      if (obs_q[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL bp_beat%0d: got %h want %h", j, obs_q[j], exp_q[j]);
      end
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_overflow: got %b want 1", overflow);
    end
    total++;
    if (fd_cnt - fd0 != 1) begin
      bad++;
      $display("FAIL bp_frame_done: got %0d pulses want 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    thresh_en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_px(8'(40 + i));
      exp_q.push_back(beat(i, 8'(40 + i)));
    end
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'd40}) begin
      bad++;
      $display("FAIL full_hold: got v=%b d=%0d want v=1 d=40", m_valid, m_data);
    end
    m_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_overflow: got %b want 0", overflow);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL full_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      total++;
      if (obs_q[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL full_beat%0d: got %h want %h", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd0;
    apply_reset();
    fd0 = fd_cnt;
    m_ready = 1'b1;
    thresh_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      push_px(8'(i * 3));
      exp_q.push_back(beat(i, 8'(i * 3)));
    end
    repeat (6) tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      total++;
      if (obs_q[j] !== exp_q[j]) begin
        bad++;
        $display("FAIL b2b_beat%0d: got %h want %h", j, obs_q[j], exp_q[j]);
      end
    end
    total++;
    if (fd_cnt - fd0 != 2) begin
      bad++;
      $display("FAIL b2b_frame_done: got %0d pulses want 2", fd_cnt - fd0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_px(8'(200 + i));
    rst = 1'b1;
    tick();
    total++;
    if ({m_valid, m_data, m_sof} !== 10'd0) begin
      bad++;
      $display("FAIL mid_reset_flush: got v=%b d=%0d sof=%b want all 0", m_valid, m_data, m_sof);
    end
    rst = 1'b0;
    obs_q.delete();
    m_ready = 1'b1;
    push_px(8'd77);
    tick();
    tick();
    total++;
    if ({m_valid, m_sof, m_eol, m_eof, m_data} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd77}) begin
      bad++;
      $display("FAIL mid_reset_sof: got v=%b sof=%b eol=%b eof=%b d=%0d want v=1 sof=1 eol=0 eof=0 d=77",
               m_valid, m_sof, m_eol, m_eof, m_data);
    end
    repeat (4) tick();
    total++;
    if (obs_q.size() != 1) begin
      bad++;
      $display("FAIL mid_reset_count: got %0d want 1", obs_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    pixel_in = '0;
    thresh_en = 1'b0;
    threshold = '0;
    m_ready = 1'b1;
    test_reset();
    test_raw();
    test_binarise();
    test_backpressure();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
